// File: rtl/phase_discriminator_if.sv
// Angle-in / frequency-out bundle between the CORDIC angle stage, the
// phase discriminator and the demodulator logic that consumes freq_out.
interface phase_discriminator_if #(
  parameter int ANGLE_W = 16
) ();
  logic signed [ANGLE_W-1:0] angle_in;
  logic                      angle_valid;
  logic                      clear;
  logic signed [ANGLE_W-1:0] freq_out;
  logic                      freq_valid;
  logic                      primed;

  modport master (
    output angle_in,
    output angle_valid,
    output clear,
    input  freq_out,
    input  freq_valid,
    input  primed
  );

  modport slave (
    input  angle_in,
    input  angle_valid,
    input  clear,
    output freq_out,
    output freq_valid,
    output primed
  );
endinterface

// File: rtl/phase_discriminator.sv
// Wrapped phase difference between consecutive CORDIC angles, averaged over
// 2^LOG2_AVG differences into one signed frequency word per block.
module phase_discriminator #(
  parameter int ANGLE_W  = 16,
  parameter int LOG2_AVG = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  phase_discriminator_if.slave   io
);

  localparam int ACC_W = ANGLE_W + LOG2_AVG;

  localparam logic [LOG2_AVG-1:0] CNT_ZERO = {LOG2_AVG{1'b0}};
  localparam logic [LOG2_AVG-1:0] CNT_ONE  = {{(LOG2_AVG-1){1'b0}}, 1'b1};
  localparam logic [LOG2_AVG-1:0] CNT_LAST = {LOG2_AVG{1'b1}};
  localparam logic [ACC_W-1:0]    ACC_ZERO = {ACC_W{1'b0}};
  localparam logic [ANGLE_W-1:0]  ANG_ZERO = {ANGLE_W{1'b0}};

  typedef enum logic [0:0] {
    ST_EMPTY  = 1'b0,
    ST_PRIMED = 1'b1
  } state_t;

  state_t                     r_state;
  logic        [ANGLE_W-1:0]  r_prev;
  logic signed [ACC_W-1:0]    r_acc;
  logic        [LOG2_AVG-1:0] r_cnt;
  logic        [ANGLE_W-1:0]  r_freq;
  logic                       r_freq_valid;
  logic                       r_primed;

  state_t                     w_state_nxt;
  logic        [ANGLE_W-1:0]  w_prev_nxt;
  logic signed [ACC_W-1:0]    w_acc_nxt;
  logic        [LOG2_AVG-1:0] w_cnt_nxt;
  logic        [ANGLE_W-1:0]  w_freq_nxt;
  logic                       w_freq_valid_nxt;
  logic                       w_primed_nxt;

  logic        [ANGLE_W-1:0]  w_diff;
  logic signed [ACC_W-1:0]    w_diff_ext;
  logic signed [ACC_W-1:0]    w_sum;
  logic                       w_last;

  // Modular subtraction wraps naturally, so a -pi/+pi crossing stays small.
  assign w_diff     = io.angle_in - r_prev;
  assign w_diff_ext = {{LOG2_AVG{w_diff[ANGLE_W-1]}}, w_diff};
  assign w_sum      = r_acc + w_diff_ext;
  assign w_last     = (r_cnt == CNT_LAST);

  // Next-state and datapath update; clear outranks a same-cycle sample.
  always_comb begin
    w_state_nxt      = r_state;
    w_prev_nxt       = r_prev;
    w_acc_nxt        = r_acc;
    w_cnt_nxt        = r_cnt;
    w_freq_nxt       = r_freq;
    w_freq_valid_nxt = 1'b0;

    if (io.clear) begin
      w_state_nxt = ST_EMPTY;
      w_acc_nxt   = ACC_ZERO;
      w_cnt_nxt   = CNT_ZERO;
    end else if (io.angle_valid) begin
      case (r_state)
        ST_EMPTY: begin
          w_prev_nxt  = io.angle_in;
          w_state_nxt = ST_PRIMED;
        end
        ST_PRIMED: begin
          w_prev_nxt = io.angle_in;
          if (w_last) begin
            // Taking the upper ANGLE_W bits is an arithmetic shift (floor).
            w_freq_nxt       = w_sum[ACC_W-1:LOG2_AVG];
            w_freq_valid_nxt = 1'b1;
            w_acc_nxt        = ACC_ZERO;
            w_cnt_nxt        = CNT_ZERO;
          end else begin
            w_acc_nxt = w_sum;
            w_cnt_nxt = r_cnt + CNT_ONE;
          end
        end
        default: begin
          w_state_nxt = ST_EMPTY;
          w_acc_nxt   = ACC_ZERO;
          w_cnt_nxt   = CNT_ZERO;
        end
      endcase
    end else begin
      w_state_nxt = r_state;
    end

    w_primed_nxt = (w_state_nxt == ST_PRIMED);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_EMPTY;
      r_prev       <= ANG_ZERO;
      r_acc        <= ACC_ZERO;
      r_cnt        <= CNT_ZERO;
      r_freq       <= ANG_ZERO;
      r_freq_valid <= 1'b0;
      r_primed     <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_prev       <= w_prev_nxt;
      r_acc        <= w_acc_nxt;
      r_cnt        <= w_cnt_nxt;
      r_freq       <= w_freq_nxt;
      r_freq_valid <= w_freq_valid_nxt;
      r_primed     <= w_primed_nxt;
    end
  end

  assign io.freq_out   = r_freq;
  assign io.freq_valid = r_freq_valid;
  assign io.primed     = r_primed;

endmodule
